// File: rtl/vnu_q_sat_buf_pkg.sv
// Shared definitions for the VNU output stage: buffer states, LLR limits, message slicing.
`ifndef VNU_MSG
`define VNU_MSG(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package vnu_q_sat_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } buf_state_t;

  function automatic int sum_w(input int data_w, input int ext_w);
    return data_w + ext_w;
  endfunction

  // Symmetric limit: LLR_MIN = -LLR_MAX, so the most negative code is never emitted.
  function automatic int llr_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/vnu_q_sat_buf_sat.sv
// Combinational symmetric clamp of one wide two's-complement message to OUT_W bits.
module llr_sat
  import vnu_q_sat_buf_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  in_v,
  output logic [OUT_W-1:0] out_v,
  output logic             sat
);

  localparam int MAXI = llr_max(OUT_W);
  localparam logic signed [IN_W-1:0] MAXV = IN_W'(MAXI);
  localparam logic signed [IN_W-1:0] MINV = IN_W'(-MAXI);

  always_comb begin
    out_v = in_v[OUT_W-1:0];
    sat   = 1'b0;
    if ($signed(in_v) > MAXV) begin
      out_v = OUT_W'(MAXI);
      sat   = 1'b1;
    end else if ($signed(in_v) < MINV) begin
      out_v = OUT_W'(-MAXI);
      sat   = 1'b1;
    end
  end

endmodule

// File: rtl/vnu_q_sat_buf.sv
// VNU output stage: per-message saturation, hard-decision flip flag, 2-entry skid buffer.
module vnu_q_sat_buf
  import vnu_q_sat_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int D      = 12,
  parameter int EXT_W  = 3,
  localparam int SUM_W = sum_w(DATA_W, EXT_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SUM_W*D-1:0]  in_q,
  input  logic                in_dec,
  input  logic                in_first,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W*D-1:0] out_q,
  output logic                out_dec,
  output logic                out_flip,
  output logic                out_sat
);

  localparam int W = DATA_W*D + 3;

  buf_state_t state, state_nxt;
  logic [W-1:0]          main_w, skid_w, new_w;
  logic [DATA_W*D-1:0]   sat_q;
  logic [D-1:0]          msg_sat;
  logic                  prev_dec, new_flip, acc, drn;

  for (genvar i = 0; i < D; i++) begin : g_sat
    llr_sat #(.IN_W(SUM_W), .OUT_W(DATA_W)) u_sat (
      .in_v  (`VNU_MSG(in_q, i, SUM_W)),
      .out_v (`VNU_MSG(sat_q, i, DATA_W)),
      .sat   (msg_sat[i])
    );
  end

  always_comb begin
    new_flip = in_first ? 1'b0 : (in_dec ^ prev_dec);
    new_w    = {sat_q, in_dec, new_flip, |msg_sat};
    acc      = in_valid & in_ready;
    drn      = out_valid & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (acc) state_nxt = ONE;
      ONE: begin
        if (acc && !drn)      state_nxt = TWO;
        else if (!acc && drn) state_nxt = EMPTY;
      end
      TWO:     if (drn) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // in_ready depends only on the state register, never on out_ready.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != TWO);
    {out_q, out_dec, out_flip, out_sat} = main_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_w   <= '0;
      skid_w   <= '0;
      prev_dec <= 1'b0;
    end else begin
      if (acc) prev_dec <= in_dec;
      case (state)
        EMPTY: if (acc) main_w <= new_w;
        ONE: begin
          if (acc && drn) main_w <= new_w;
          else if (acc)   skid_w <= new_w;
        end
        TWO:     if (drn) main_w <= skid_w;
        default: ;
      endcase
    end
  end

endmodule
